// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the instruction fetch stage and its consumers.
//   fetch_state_e : fetch controller states (BOOT, RUN, HALT)
//   NOP_INSTR_C   : bubble encoding (addi x0,x0,0) placed in IF/ID
//   PC_INCR       : byte distance between sequential instructions
//   if_id_t       : IF/ID record {pc, instr, valid} for the decode stage
package instr_fetch_pkg;

  localparam int          IF_ADDR_WIDTH = 8;
  localparam int          PC_INCR       = 4;
  localparam logic [31:0] NOP_INSTR_C   = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [IF_ADDR_WIDTH-1:0] pc;
    logic [31:0]              instr;
    logic                     valid;
  } if_id_t;

endpackage

// File: rtl/instr_fetch_stage_if_id_reg.sv
// IF/ID pipeline register.
//   clk, reset        : clock, synchronous active-high reset
//   hold              : keep the current contents (stall / boot)
//   flush             : replace contents with a bubble (wins over hold)
//   next_pc/next_instr: instruction captured when neither hold nor flush
//   pc, instr, valid  : registered IF/ID contents
// A bubble keeps the last pc value; only instr and valid mark it as empty.
module if_id_reg
  import instr_fetch_pkg::*;
#(
  parameter int          ADDR_WIDTH = IF_ADDR_WIDTH,
  parameter logic [31:0] NOP_INSTR  = NOP_INSTR_C
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  hold,
  input  logic                  flush,
  input  logic [ADDR_WIDTH-1:0] next_pc,
  input  logic [31:0]           next_instr,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic [31:0]           instr,
  output logic                  valid
);

  // NOTE: state registers are written with non-blocking assignments so every
  // flop samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc    <= '0;
      instr <= NOP_INSTR;
      valid <= 1'b0;
    end else if (flush) begin
      instr <= NOP_INSTR;
      valid <= 1'b0;
    end else if (!hold) begin
      pc    <= next_pc;
      instr <= next_instr;
      valid <= 1'b1;
    end
  end

endmodule

// File: rtl/instr_fetch_stage.sv
// Instruction fetch stage: owns the PC, addresses an asynchronous-read
// instruction memory and fills the IF/ID register for decode.
//   clk, reset        : clock, synchronous active-high reset
//   stall             : decode hazard; freeze PC and IF/ID
//   branch_taken      : redirect from execute to branch_target (word aligned)
//   halt              : stop fetching until reset
//   instruction       : memory word for inst_addr, same cycle
//   inst_addr         : memory byte address (the PC register)
//   if_id_pc/instr/valid : IF/ID contents
//   fetch_count       : saturating count of valid instructions latched
//   halted            : controller is in HALT
module instr_fetch_stage
  import instr_fetch_pkg::*;
#(
  parameter int                    ADDR_WIDTH  = IF_ADDR_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0,
  parameter logic [31:0]           NOP_INSTR   = NOP_INSTR_C,
  parameter int                    COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   stall,
  input  logic                   branch_taken,
  input  logic [ADDR_WIDTH-1:0]  branch_target,
  input  logic                   halt,
  input  logic [31:0]            instruction,
  output logic [ADDR_WIDTH-1:0]  inst_addr,
  output logic [ADDR_WIDTH-1:0]  if_id_pc,
  output logic [31:0]            if_id_instr,
  output logic                   if_id_valid,
  output logic [COUNT_WIDTH-1:0] fetch_count,
  output logic                   halted
);

  localparam logic [ADDR_WIDTH-1:0] PC_STEP = ADDR_WIDTH'(PC_INCR);

  fetch_state_e          state;
  logic [ADDR_WIDTH-1:0] pc;
  logic                  capture;
  logic                  flush;

  assign inst_addr = pc;

  // IF/ID control: halt and redirect both squash the instruction currently
  // being fetched; HALT keeps re-asserting the bubble; BOOT and stall hold.
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    capture = 1'b0;
    flush   = 1'b0;
    unique case (state)
      ST_RUN: begin
        if (halt || branch_taken) flush = 1'b1;
        else if (!stall)          capture = 1'b1;
      end
      ST_HALT: flush = 1'b1;
      default: ;
    endcase
  end

  // Controller, PC and counter. Priority in RUN: halt, branch, stall, fetch.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_BOOT;
      pc          <= RESET_PC;
      fetch_count <= '0;
      halted      <= 1'b0;
    end else begin
      unique case (state)
        ST_BOOT: state <= ST_RUN;
        ST_RUN: begin
          if (halt) begin
            state  <= ST_HALT;
            halted <= 1'b1;
          end else if (branch_taken) begin
            pc <= {branch_target[ADDR_WIDTH-1:2], 2'b00};
          end else if (!stall) begin
            pc <= pc + PC_STEP;
            if (fetch_count != '1) fetch_count <= fetch_count + 1'b1;
          end
        end
        ST_HALT: ;
        default: state <= ST_BOOT;
      endcase
    end
  end

  if_id_reg #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .NOP_INSTR  (NOP_INSTR)
  ) u_if_id (
    .clk        (clk),
    .reset      (reset),
    .hold       (!capture),
    .flush      (flush),
    .next_pc    (pc),
    .next_instr (instruction),
    .pc         (if_id_pc),
    .instr      (if_id_instr),
    .valid      (if_id_valid)
  );

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Self-checking bench for instr_fetch_stage: directed program walk-through,
// randomized control traffic against a behavioural model, and a counter
// saturation check on a second instance with a 4-bit counter.
module tb_instr_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset, stall, branch_taken, halt;
  logic [7:0]  branch_target;
  logic [31:0] instruction, instruction4;
  logic [7:0]  inst_addr, if_id_pc, inst_addr4, if_id_pc4;
  logic [31:0] if_id_instr, if_id_instr4;
  logic        if_id_valid, halted, if_id_valid4, halted4;
  logic [15:0] fetch_count;
  logic [3:0]  fetch_count4;

  logic [31:0] mem [64];

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  logic [7:0]  m_pc, m_if_pc;
  logic [31:0] m_if_instr;
  logic        m_if_valid, m_halted, m_booting;
  int          m_count;

  always #5 clk = ~clk;

  assign instruction  = mem[inst_addr[7:2]];
  assign instruction4 = mem[inst_addr4[7:2]];

  instr_fetch_stage dut (
    .clk(clk), .reset(reset), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .halt(halt), .instruction(instruction),
    .inst_addr(inst_addr), .if_id_pc(if_id_pc), .if_id_instr(if_id_instr),
    .if_id_valid(if_id_valid), .fetch_count(fetch_count), .halted(halted)
  );

  instr_fetch_stage #(.COUNT_WIDTH(4)) dut4 (
    .clk(clk), .reset(reset), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .halt(halt), .instruction(instruction4),
    .inst_addr(inst_addr4), .if_id_pc(if_id_pc4), .if_id_instr(if_id_instr4),
    .if_id_valid(if_id_valid4), .fetch_count(fetch_count4), .halted(halted4)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs,
                          input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock edge of the specified behaviour.
  task automatic model_step(input logic r, st, br, input logic [7:0] tgt,
                            input logic h);
    if (r) begin
      m_pc = 8'h00; m_if_pc = 8'h00; m_if_instr = NOP; m_if_valid = 1'b0;
      m_count = 0; m_halted = 1'b0; m_booting = 1'b1;
    end else if (m_booting) begin
      m_booting = 1'b0;
    end else if (m_halted) begin
      m_if_instr = NOP; m_if_valid = 1'b0;
    end else if (h) begin
      m_halted = 1'b1; m_if_instr = NOP; m_if_valid = 1'b0;
    end else if (br) begin
      m_pc = tgt & 8'hFC; m_if_instr = NOP; m_if_valid = 1'b0;
    end else if (!st) begin
      m_if_pc = m_pc; m_if_instr = mem[m_pc[7:2]]; m_if_valid = 1'b1;
      m_pc = 8'((int'(m_pc) + 4) % 256);
      m_count++;
    end
  endtask

  task automatic compare_all();
    int sat16, sat4;
    sat16 = (m_count > 65535) ? 65535 : m_count;
    sat4  = (m_count > 15) ? 15 : m_count;
    check_eq("inst_addr",   {24'b0, inst_addr},  {24'b0, m_pc});
    check_eq("if_id_instr", if_id_instr,         m_if_instr);
    check_eq("if_id_valid", {31'b0, if_id_valid}, {31'b0, m_if_valid});
    if (m_if_valid) check_eq("if_id_pc", {24'b0, if_id_pc}, {24'b0, m_if_pc});
    check_eq("fetch_count", {16'b0, fetch_count}, sat16);
    check_eq("halted",      {31'b0, halted},      {31'b0, m_halted});
    check_eq("fetch_count4", {28'b0, fetch_count4}, sat4);
    check_eq("inst_addr4",  {24'b0, inst_addr4}, {24'b0, m_pc});
  endtask

  // Apply inputs, take one edge, update the model, then sample #1 later.
  task automatic step(input logic r, st, br, input logic [7:0] tgt,
                      input logic h);
    reset = r; stall = st; branch_taken = br; branch_target = tgt; halt = h;
    @(posedge clk);
    model_step(r, st, br, tgt, h);
    #1;
    compare_all();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = $urandom;
    mem[0]  = 32'h0000_7033;
    mem[1]  = 32'h0010_0093;
    mem[2]  = 32'h0020_0113;
    mem[3]  = 32'h0030_8193;
    mem[18] = 32'h02b0_2823;

    // Reset, then BOOT: address stays 0 and nothing valid.
    step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    check_eq("rst_addr",  {24'b0, inst_addr}, 32'h00);
    check_eq("rst_instr", if_id_instr, NOP);
    check_eq("rst_pc",    {24'b0, if_id_pc}, 32'h00);
    step(1'b0, 1'b1, 1'b1, 8'h40, 1'b0);   // BOOT ignores stall/branch
    check_eq("boot_addr",  {24'b0, inst_addr}, 32'h00);
    check_eq("boot_valid", {31'b0, if_id_valid}, 32'h0);

    run(1);
    check_eq("f0_pc",    {24'b0, if_id_pc}, 32'h00);
    check_eq("f0_instr", if_id_instr, 32'h0000_7033);
    check_eq("f0_valid", {31'b0, if_id_valid}, 32'h1);
    run(1);
    check_eq("f1_pc",    {24'b0, if_id_pc}, 32'h04);
    check_eq("f1_instr", if_id_instr, 32'h0010_0093);
    run(1);

    // Stall for three cycles with IF/ID at 0x08.
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
      check_eq("stall_pc",    {24'b0, if_id_pc}, 32'h08);
      check_eq("stall_instr", if_id_instr, 32'h0020_0113);
      check_eq("stall_addr",  {24'b0, inst_addr}, 32'h0C);
      check_eq("stall_cnt",   {16'b0, fetch_count}, 32'd3);
    end
    run(1);
    check_eq("unstall_pc",    {24'b0, if_id_pc}, 32'h0C);
    check_eq("unstall_instr", if_id_instr, 32'h0030_8193);

    // Branch to an unaligned target together with stall.
    step(1'b0, 1'b1, 1'b1, 8'h4A, 1'b0);
    check_eq("br_instr", if_id_instr, NOP);
    check_eq("br_valid", {31'b0, if_id_valid}, 32'h0);
    check_eq("br_addr",  {24'b0, inst_addr}, 32'h48);
    run(1);
    check_eq("br_tgt_pc",    {24'b0, if_id_pc}, 32'h48);
    check_eq("br_tgt_instr", if_id_instr, 32'h02b0_2823);

    // PC wrap.
    step(1'b0, 1'b0, 1'b1, 8'hFC, 1'b0);
    check_eq("wrap_addr0", {24'b0, inst_addr}, 32'hFC);
    run(1);
    check_eq("wrap_addr1", {24'b0, inst_addr}, 32'h00);
    check_eq("wrap_pc1",   {24'b0, if_id_pc}, 32'hFC);
    run(1);
    check_eq("wrap_pc2",   {24'b0, if_id_pc}, 32'h00);

    // Walk to 0x10, then halt while other controls toggle.
    run(3);
    check_eq("pre_halt_addr", {24'b0, inst_addr}, 32'h10);
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'(i), 1'(~i), 8'h80, 1'(i >> 1));
      check_eq("halt_flag",  {31'b0, halted}, 32'h1);
      check_eq("halt_valid", {31'b0, if_id_valid}, 32'h0);
      check_eq("halt_addr",  {24'b0, inst_addr}, 32'h10);
    end
    step(1'b1, 1'b1, 1'b1, 8'h80, 1'b1);   // reset wins over everything
    check_eq("rehalt_rst_addr", {24'b0, inst_addr}, 32'h00);
    check_eq("rehalt_halted",   {31'b0, halted}, 32'h0);

    // Randomized control traffic.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(99) == 0), ($urandom_range(3) == 0),
           ($urandom_range(7) == 0), 8'($urandom), ($urandom_range(79) == 0));
    end

    // Counter saturation on the 4-bit instance: boot plus 20 fetches.
    step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    run(21);
    check_eq("sat_cnt4",  {28'b0, fetch_count4}, 32'hF);
    check_eq("sat_cnt16", {16'b0, fetch_count}, 32'd20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
